// File: rtl/riscv_pkg.sv
// RV64I decode types: opcodes, ALU ops, PC-select encoding, immediate formats and the ID/EX bundle.
package riscv_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcOp32    = 7'b0111011;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluLui   = 4'd10,
        AluAuipc = 4'd11,
        AluLink  = 4'd12
    } alu_op_t;

    // Shared with fetch: must keep this encoding.
    typedef enum logic [1:0] {
        PcSel4    = 2'b00,
        PcSelBr   = 2'b01,
        PcSelJal  = 2'b10,
        PcSelJalr = 2'b11
    } pcsel_t;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ,
        ImmShamt6,
        ImmShamt5
    } imm_fmt_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        alu_op_t         alu_op;
        pcsel_t          pcsel;
        logic [2:0]      funct3;
        logic            mem_rd;
        logic            mem_wr;
        logic            wb_en;
        logic            word;
    } id_bundle_t;

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            ImmI:      imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            ImmS:      imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:      imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            ImmU:      imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            ImmJ:      imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            ImmShamt6: imm = {{(XLEN-6){1'b0}}, instr[25:20]};
            ImmShamt5: imm = {{(XLEN-5){1'b0}}, instr[24:20]};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

    // alt selects SUB/SRA over ADD/SRL.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: two combinational read ports with write-through bypass, one write port,
// x0 hardwired to zero.
module decode_stage_regfile
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [$clog2(NREGS)-1:0] raddr1_i,
    input  logic [$clog2(NREGS)-1:0] raddr2_i,
    output logic [XLEN-1:0]          rdata1_o,
    output logic [XLEN-1:0]          rdata2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i && waddr_i != '0) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1_o = (raddr1_i == '0)                   ? '0      :
                      (we_i && waddr_i == raddr1_i)      ? wdata_i : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                   ? '0      :
                      (we_i && waddr_i == raddr2_i)      ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage with a 1-entry ID/EX register. Define DECODE_ILLEGAL_CHK_EN to flag
// illegal encodings on id_illegal; otherwise they decode silently as NOP.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rd,
    output logic [3:0]      id_alu_op,
    output logic [1:0]      id_pcsel,
    output logic [2:0]      id_funct3,
    output logic            id_mem_rd,
    output logic            id_mem_wr,
    output logic            id_wb_en,
    output logic            id_word,
`ifdef DECODE_ILLEGAL_CHK_EN
    output logic            id_illegal,
`endif
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] instr_rd, instr_rs1, instr_rs2;

    assign opcode    = if_instr[6:0];
    assign instr_rd  = if_instr[11:7];
    assign funct3    = if_instr[14:12];
    assign instr_rs1 = if_instr[19:15];
    assign instr_rs2 = if_instr[24:20];
    assign funct7    = if_instr[31:25];

    logic       dec_legal, dec_mem_rd, dec_mem_wr, dec_wb, dec_word, dec_use_rs1, dec_use_rs2;
    logic [2:0] dec_funct3;
    logic [4:0] dec_rd, dec_rs1, dec_rs2;
    imm_fmt_t   dec_fmt;
    alu_op_t    dec_alu;
    pcsel_t     dec_pcsel;

    always_comb begin
        dec_legal   = 1'b1;
        dec_fmt     = ImmNone;
        dec_alu     = AluAdd;
        dec_pcsel   = PcSel4;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_wb      = 1'b0;
        dec_word    = 1'b0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        case (opcode)
            OpcLui: begin
                dec_fmt = ImmU;
                dec_alu = AluLui;
                dec_wb  = 1'b1;
            end
            OpcAuipc: begin
                dec_fmt = ImmU;
                dec_alu = AluAuipc;
                dec_wb  = 1'b1;
            end
            OpcJal: begin
                dec_fmt   = ImmJ;
                dec_alu   = AluLink;
                dec_pcsel = PcSelJal;
                dec_wb    = 1'b1;
            end
            OpcJalr: begin
                dec_legal   = (funct3 == 3'b000);
                dec_fmt     = ImmI;
                dec_alu     = AluLink;
                dec_pcsel   = PcSelJalr;
                dec_wb      = 1'b1;
                dec_use_rs1 = 1'b1;
            end
            OpcBranch: begin
                dec_legal   = (funct3[2:1] != 2'b01);
                dec_fmt     = ImmB;
                dec_alu     = AluSub;
                dec_pcsel   = PcSelBr;
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            OpcLoad: begin
                dec_legal   = (funct3 != 3'b111);
                dec_fmt     = ImmI;
                dec_mem_rd  = 1'b1;
                dec_wb      = 1'b1;
                dec_use_rs1 = 1'b1;
            end
            OpcStore: begin
                dec_legal   = !funct3[2];
                dec_fmt     = ImmS;
                dec_mem_wr  = 1'b1;
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            OpcOpImm: begin
                dec_wb      = 1'b1;
                dec_use_rs1 = 1'b1;
                dec_fmt     = ImmI;
                dec_alu     = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt   = ImmShamt6;
                    dec_legal = (funct7[6:1] == 6'b000000) ||
                                (funct3 == 3'b101 && funct7[6:1] == 6'b010000);
                end
            end
            OpcOp: begin
                dec_wb      = 1'b1;
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_alu     = alu_from_funct3(funct3, funct7[5]);
                dec_legal   = (funct7 == 7'h00) ||
                              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OpcOpImm32: begin
                dec_wb      = 1'b1;
                dec_word    = 1'b1;
                dec_use_rs1 = 1'b1;
                dec_alu     = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                dec_fmt     = (funct3 == 3'b000) ? ImmI : ImmShamt5;
                dec_legal   = (funct3 == 3'b000) ||
                              (funct3 == 3'b001 && funct7 == 7'h00) ||
                              (funct3 == 3'b101 && (funct7 == 7'h00 || funct7 == 7'h20));
            end
            OpcOp32: begin
                dec_wb      = 1'b1;
                dec_word    = 1'b1;
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_alu     = alu_from_funct3(funct3, funct7[5]);
                dec_legal   = ((funct3 == 3'b000 || funct3 == 3'b101) &&
                               (funct7 == 7'h00 || funct7 == 7'h20)) ||
                              (funct3 == 3'b001 && funct7 == 7'h00);
            end
            default: dec_legal = 1'b0;
        endcase

        // Anything not legal collapses to the addi x0,x0,0 bundle.
        if (!dec_legal) begin
            dec_fmt     = ImmNone;
            dec_alu     = AluAdd;
            dec_pcsel   = PcSel4;
            dec_mem_rd  = 1'b0;
            dec_mem_wr  = 1'b0;
            dec_wb      = 1'b0;
            dec_word    = 1'b0;
            dec_use_rs1 = 1'b0;
            dec_use_rs2 = 1'b0;
        end
        dec_funct3 = dec_legal ? funct3 : 3'b000;
        dec_rd     = dec_wb ? instr_rd : 5'd0;
        dec_rs1    = dec_use_rs1 ? instr_rs1 : 5'd0;
        dec_rs2    = dec_use_rs2 ? instr_rs2 : 5'd0;
    end

    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;

    decode_stage_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_en),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (dec_rs1),
        .raddr2_i (dec_rs2),
        .rdata1_o (rf_rs1_data),
        .rdata2_o (rf_rs2_data)
    );

    id_bundle_t id_q, id_d;
    logic       capture, stall;

    assign if_ready = !id_q.valid || ex_ready;
    assign capture  = if_valid && if_ready;
    assign stall    = id_q.valid && !ex_ready;

    always_comb begin
        id_d = id_q;
        if (flush) begin
            id_d.valid = 1'b0;
        end else if (capture) begin
            // An all-zero word is consumed as a bubble.
            id_d.valid = (if_instr != 32'd0);
            if (if_instr != 32'd0) begin
                id_d.pc      = if_pc;
                id_d.rs1_val = rf_rs1_data;
                id_d.rs2_val = rf_rs2_data;
                id_d.imm     = gen_imm(if_instr, dec_fmt);
                id_d.rd      = dec_rd;
                id_d.rs1_idx = dec_rs1;
                id_d.rs2_idx = dec_rs2;
                id_d.alu_op  = dec_alu;
                id_d.pcsel   = dec_pcsel;
                id_d.funct3  = dec_funct3;
                id_d.mem_rd  = dec_mem_rd;
                id_d.mem_wr  = dec_mem_wr;
                id_d.wb_en   = dec_wb && (dec_rd != 5'd0);
                id_d.word    = dec_word;
            end
        end else if (stall) begin
            // Keep held operands coherent with writebacks that land during the stall.
            if (wb_en && wb_rd == id_q.rs1_idx && id_q.rs1_idx != 5'd0) id_d.rs1_val = wb_data;
            if (wb_en && wb_rd == id_q.rs2_idx && id_q.rs2_idx != 5'd0) id_d.rs2_val = wb_data;
        end else begin
            id_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

`ifdef DECODE_ILLEGAL_CHK_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (!flush && capture && if_instr != 32'd0) begin
            illegal_d = !dec_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign id_illegal = illegal_q;
`endif

    assign id_valid   = id_q.valid;
    assign id_pc      = id_q.pc;
    assign id_rs1_val = id_q.rs1_val;
    assign id_rs2_val = id_q.rs2_val;
    assign id_imm     = id_q.imm;
    assign id_rd      = id_q.rd;
    assign id_alu_op  = id_q.alu_op;
    assign id_pcsel   = id_q.pcsel;
    assign id_funct3  = id_q.funct3;
    assign id_mem_rd  = id_q.mem_rd;
    assign id_mem_wr  = id_q.mem_wr;
    assign id_wb_en   = id_q.wb_en;
    assign id_word    = id_q.word;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus stall/flush/bypass/reset sequences.
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, if_ready, flush, ex_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_valid, id_mem_rd, id_mem_wr, id_wb_en, id_word;
    logic [63:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_pcsel;
    logic [2:0]  id_funct3;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
`ifdef DECODE_ILLEGAL_CHK_EN
    logic        id_illegal;
`endif

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_rs1_val (id_rs1_val),
        .id_rs2_val (id_rs2_val),
        .id_imm     (id_imm),
        .id_rd      (id_rd),
        .id_alu_op  (id_alu_op),
        .id_pcsel   (id_pcsel),
        .id_funct3  (id_funct3),
        .id_mem_rd  (id_mem_rd),
        .id_mem_wr  (id_mem_wr),
        .id_wb_en   (id_wb_en),
        .id_word    (id_word),
`ifdef DECODE_ILLEGAL_CHK_EN
        .id_illegal (id_illegal),
`endif
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  rd;
        alu_op_t     alu;
        pcsel_t      pcsel;
        logic [2:0]  f3;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb;
        logic        word;
        logic        valid;
        logic        illegal;
    } vec_t;

    vec_t vecs [13];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [63:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [63:0] data);
        wb_en   = en;
        wb_rd   = rd;
        wb_data = data;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(id_valid), 64'd0);
        chk({tag, "_pc"}, id_pc, 64'd0);
        chk({tag, "_rs1"}, id_rs1_val, 64'd0);
        chk({tag, "_rs2"}, id_rs2_val, 64'd0);
        chk({tag, "_imm"}, id_imm, 64'd0);
        chk({tag, "_rd"}, 64'(id_rd), 64'd0);
        chk({tag, "_alu"}, 64'(id_alu_op), 64'd0);
        chk({tag, "_pcsel"}, 64'(id_pcsel), 64'd0);
        chk({tag, "_f3"}, 64'(id_funct3), 64'd0);
        chk({tag, "_ctl"}, {60'd0, id_mem_rd, id_mem_wr, id_wb_en, id_word}, 64'd0);
        chk({tag, "_if_ready"}, 64'(if_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        //          instr          pc         imm                    rs1        rs2        rd
        vecs[0]  = '{32'hFFF00293, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 5'd5,
                     AluAdd, PcSel4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'hFE208EE3, 64'h1004, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1111, 64'h2222, 5'd0,
                     AluSub, PcSelBr, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h008000EF, 64'h1008, 64'h8, 64'h0, 64'h0, 5'd1,
                     AluLink, PcSelJal, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h800001B7, 64'h100C, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h0, 5'd3,
                     AluLui, PcSel4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h01013203, 64'h1010, 64'h10, 64'h2222, 64'h0, 5'd4,
                     AluAdd, PcSel4, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'hFE20BC23, 64'h1014, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1111, 64'h2222, 5'd0,
                     AluAdd, PcSel4, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'h43F0D293, 64'h1018, 64'h3F, 64'h1111, 64'h0, 5'd5,
                     AluSra, PcSel4, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h4020833B, 64'h101C, 64'h0, 64'h1111, 64'h2222, 5'd6,
                     AluSub, PcSel4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h01F1139B, 64'h1020, 64'h1F, 64'h2222, 64'h0, 5'd7,
                     AluSll, PcSel4, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h00008067, 64'h1024, 64'h0, 64'h1111, 64'h0, 5'd0,
                     AluLink, PcSelJalr, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h12345497, 64'h1028, 64'h1234_5000, 64'h0, 64'h0, 5'd9,
                     AluAuipc, PcSel4, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{32'h022081B3, 64'h102C, 64'h0, 64'h0, 64'h0, 5'd0,
                     AluAdd, PcSel4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{32'h00000000, 64'h1030, 64'h0, 64'h0, 64'h0, 5'd0,
                     AluAdd, PcSel4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset dominates a pending instruction.
        reset    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        present(32'hFFF00293, 64'h40);
        wb(1'b0, 5'd0, 64'd0);
        tick();
        tick();
        chk_all_zero("reset");
        reset    = 1'b1;
        if_valid = 1'b0;
        ex_ready = 1'b1;

        wb(1'b1, 5'd1, 64'h1111);
        tick();
        wb(1'b1, 5'd2, 64'h2222);
        tick();
        wb(1'b0, 5'd0, 64'd0);

        for (int i = 0; i < 13; i++) begin
            present(vecs[i].instr, vecs[i].pc);
            tick();
            chk($sformatf("v%0d_valid", i), 64'(id_valid), 64'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_pc", i), id_pc, vecs[i].pc);
                chk($sformatf("v%0d_imm", i), id_imm, vecs[i].imm);
                chk($sformatf("v%0d_rs1", i), id_rs1_val, vecs[i].rs1);
                chk($sformatf("v%0d_rs2", i), id_rs2_val, vecs[i].rs2);
                chk($sformatf("v%0d_rd", i), 64'(id_rd), 64'(vecs[i].rd));
                chk($sformatf("v%0d_alu", i), 64'(id_alu_op), 64'(vecs[i].alu));
                chk($sformatf("v%0d_pcsel", i), 64'(id_pcsel), 64'(vecs[i].pcsel));
                chk($sformatf("v%0d_f3", i), 64'(id_funct3), 64'(vecs[i].f3));
                chk($sformatf("v%0d_ctl", i), {60'd0, id_mem_rd, id_mem_wr, id_wb_en, id_word},
                    {60'd0, vecs[i].mem_rd, vecs[i].mem_wr, vecs[i].wb, vecs[i].word});
`ifdef DECODE_ILLEGAL_CHK_EN
                chk($sformatf("v%0d_illegal", i), 64'(id_illegal), 64'(vecs[i].illegal));
`endif
            end
        end

        // Same-cycle writeback is bypassed to both operands: add x7,x6,x6.
        present(32'h006303B3, 64'h1100);
        wb(1'b1, 5'd6, 64'h55);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        chk("bypass_rs1", id_rs1_val, 64'h55);
        chk("bypass_rs2", id_rs2_val, 64'h55);

        // Writes to x0 neither land nor bypass: add x1,x0,x0.
        present(32'h000000B3, 64'h1104);
        wb(1'b1, 5'd0, 64'hFF);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        chk("x0_bypass", id_rs1_val, 64'h0);
        chk("x0_rd", 64'(id_rd), 64'd1);

        if_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(id_valid), 64'd0);

        // Stall: add x7,x6,x1 held for 3 cycles while addi x8,x0,5 waits.
        present(32'h001303B3, 64'h2000);
        ex_ready = 1'b0;
        tick();
        chk("stall_cap_valid", 64'(id_valid), 64'd1);
        chk("stall_cap_rs1", id_rs1_val, 64'h55);
        chk("stall_cap_rs2", id_rs2_val, 64'h1111);
        chk("stall_if_ready", 64'(if_ready), 64'd0);
        present(32'h00500413, 64'h2004);
        tick();
        chk("stall1_pc", id_pc, 64'h2000);
        wb(1'b1, 5'd6, 64'hABC);
        tick();
        wb(1'b0, 5'd0, 64'd0);
        chk("stall2_refresh_rs1", id_rs1_val, 64'hABC);
        chk("stall2_rs2", id_rs2_val, 64'h1111);
        chk("stall2_pc", id_pc, 64'h2000);
        tick();
        chk("stall3_pc", id_pc, 64'h2000);
        chk("stall3_rd", 64'(id_rd), 64'd7);
        chk("stall3_if_ready", 64'(if_ready), 64'd0);
        ex_ready = 1'b1;
        #1;
        chk("release_if_ready", 64'(if_ready), 64'd1);
        tick();
        chk("release_valid", 64'(id_valid), 64'd1);
        chk("release_pc", id_pc, 64'h2004);
        chk("release_imm", id_imm, 64'h5);
        chk("release_rd", 64'(id_rd), 64'd8);

        // Flush kills a coincident jal capture; the writeback still commits.
        present(32'h008000EF, 64'h3000);
        flush = 1'b1;
        wb(1'b1, 5'd10, 64'h77);
        tick();
        flush = 1'b0;
        wb(1'b0, 5'd0, 64'd0);
        chk("flush_valid", 64'(id_valid), 64'd0);
        present(32'h000505B3, 64'h3004);
        tick();
        chk("post_flush_valid", 64'(id_valid), 64'd1);
        chk("post_flush_rs1", id_rs1_val, 64'h77);
        chk("post_flush_pc", id_pc, 64'h3004);

        // Reset in the middle of a stall.
        present(32'h002081B3, 64'h4000);
        tick();
        ex_ready = 1'b0;
        tick();
        chk("pre_reset_held", 64'(id_valid), 64'd1);
        reset = 1'b0;
        tick();
        chk_all_zero("midreset");
        reset    = 1'b1;
        ex_ready = 1'b1;
        present(32'h002081B3, 64'h4004);
        tick();
        chk("rst_x1", id_rs1_val, 64'h0);
        chk("rst_x2", id_rs2_val, 64'h0);
        present(32'h00A30233, 64'h4008);
        tick();
        chk("rst_x6", id_rs1_val, 64'h0);
        chk("rst_x10", id_rs2_val, 64'h0);

        // Opcode 0x7F: NOP bundle, flagged when the checker is built in.
        present(32'hFFFFFFFF, 64'h400C);
        tick();
        if_valid = 1'b0;
        chk("op7f_valid", 64'(id_valid), 64'd1);
        chk("op7f_ctl", {60'd0, id_mem_rd, id_mem_wr, id_wb_en, id_word}, 64'd0);
        chk("op7f_rd", 64'(id_rd), 64'd0);
        chk("op7f_imm", id_imm, 64'd0);
`ifdef DECODE_ILLEGAL_CHK_EN
        chk("op7f_illegal", 64'(id_illegal), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
